// File: rtl/intan_spi_responder.sv
// Intan-style SPI command responder: synchronizes the SPI pins into bus_clk, decodes 16-bit
// commands and returns each response two accepted words later. Optional: INTAN_RESP_FRAME_CHECK_EN.
module intan_spi_responder #(
  parameter logic [7:0] CHIP_ID  = 8'd1,
  parameter int         RAM_REGS = 22
) (
  input  logic        bus_clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  output logic        word_valid,
  output logic [15:0] last_cmd,
  output logic        frame_err,
  output logic [7:0]  frame_err_cnt
);

  typedef enum logic [1:0] {ST_DISARMED, ST_IDLE, ST_ACTIVE} state_e;

  state_e      state_q, state_d;
  logic        sclk_meta_q, sclk_sync_q, sclk_dly_q;
  logic        cs_meta_q, cs_sync_q, cs_dly_q;
  logic        mosi_meta_q, mosi_sync_q, mosi_dly_q;
  logic [4:0]  bit_cnt_q;
  logic [15:0] rx_shift_q, tx_shift_q;
  logic [15:0] pipe_new_q, pipe_old_q;
  logic [15:0] last_cmd_q;
  logic        word_valid_q;
  logic [9:0]  conv_cnt_q;
  logic [7:0]  ram_q [RAM_REGS];

  logic        sclk_rise, sclk_fall, cs_rise, cs_fall, cs_edge;
  logic        word_start, accept;
  logic [1:0]  opcode;
  logic [5:0]  reg_addr;
  logic [7:0]  wr_data, rd_data;
  logic [15:0] response;

  // CS syncs reset low so an idle-high CS yields a rise right after reset, which arms the responder.
  always_ff @(posedge bus_clk) begin
    if (reset) begin
      {sclk_meta_q, sclk_sync_q, sclk_dly_q} <= 3'b000;
      {cs_meta_q, cs_sync_q, cs_dly_q}       <= 3'b000;
      {mosi_meta_q, mosi_sync_q, mosi_dly_q} <= 3'b000;
    end else begin
      {sclk_meta_q, sclk_sync_q, sclk_dly_q} <= {SCLK, sclk_meta_q, sclk_sync_q};
      {cs_meta_q, cs_sync_q, cs_dly_q}       <= {CS, cs_meta_q, cs_sync_q};
      {mosi_meta_q, mosi_sync_q, mosi_dly_q} <= {MOSI, mosi_meta_q, mosi_sync_q};
    end
  end

  assign sclk_rise = sclk_sync_q & ~sclk_dly_q;
  assign sclk_fall = ~sclk_sync_q & sclk_dly_q;
  assign cs_rise   = cs_sync_q & ~cs_dly_q;
  assign cs_fall   = ~cs_sync_q & cs_dly_q;
  assign cs_edge   = cs_rise | cs_fall;

  always_ff @(posedge bus_clk) begin
    if (reset) state_q <= ST_DISARMED;
    else       state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    word_start = 1'b0;
    accept     = 1'b0;
    case (state_q)
      ST_DISARMED: if (cs_rise) state_d = ST_IDLE;
      ST_IDLE: if (cs_fall) begin
        state_d    = ST_ACTIVE;
        word_start = 1'b1;
      end
      ST_ACTIVE: if (cs_rise) begin
        state_d = ST_IDLE;
        accept  = (bit_cnt_q == 5'd16);
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  assign opcode   = rx_shift_q[15:14];
  assign reg_addr = rx_shift_q[13:8];
  assign wr_data  = rx_shift_q[7:0];

  always_comb begin
    case (reg_addr)
      6'd40:   rd_data = 8'h49;
      6'd41:   rd_data = 8'h4E;
      6'd42:   rd_data = 8'h54;
      6'd43:   rd_data = 8'h41;
      6'd44:   rd_data = 8'h4E;
      6'd63:   rd_data = CHIP_ID;
      default: rd_data = 8'h00;
    endcase
    for (int i = 0; i < RAM_REGS; i++)
      if (reg_addr == 6'(i)) rd_data = ram_q[i];
  end

  always_comb begin
    case (opcode)
      2'b00:   response = {reg_addr, conv_cnt_q};
      2'b10:   response = {8'hFF, wr_data};
      2'b11:   response = {8'h00, rd_data};
      default: response = 16'h0000;
    endcase
  end

  // NOTE: the register file is reset element by element because a cleared RAM is visible behaviour.
  always_ff @(posedge bus_clk) begin
    if (reset) begin
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      pipe_new_q   <= '0;
      pipe_old_q   <= '0;
      last_cmd_q   <= '0;
      word_valid_q <= 1'b0;
      conv_cnt_q   <= '0;
      for (int i = 0; i < RAM_REGS; i++) ram_q[i] <= 8'h00;
    end else begin
      word_valid_q <= accept;
      if (word_start) begin
        bit_cnt_q  <= '0;
        rx_shift_q <= '0;
        tx_shift_q <= pipe_old_q;
      end else if (state_q == ST_ACTIVE && !cs_edge) begin
        if (sclk_rise) begin
          rx_shift_q <= {rx_shift_q[14:0], mosi_dly_q};
          if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 5'd1;
        end
        if (sclk_fall) tx_shift_q <= {tx_shift_q[14:0], 1'b0};
      end
      if (accept) begin
        last_cmd_q <= rx_shift_q;
        pipe_old_q <= pipe_new_q;
        pipe_new_q <= response;
        if (opcode == 2'b00) conv_cnt_q <= conv_cnt_q + 10'd1;
      end
      for (int i = 0; i < RAM_REGS; i++)
        if (accept && opcode == 2'b10 && reg_addr == 6'(i)) ram_q[i] <= wr_data;
    end
  end

  assign MISO       = (state_q == ST_ACTIVE) & tx_shift_q[15];
  assign word_valid = word_valid_q;
  assign last_cmd   = last_cmd_q;

`ifdef INTAN_RESP_FRAME_CHECK_EN
  logic       malformed;
  logic       frame_err_q;
  logic [7:0] frame_err_cnt_q;

  assign malformed = (state_q == ST_ACTIVE) && cs_rise && (bit_cnt_q != 5'd16);

  always_ff @(posedge bus_clk) begin
    if (reset) begin
      frame_err_q     <= 1'b0;
      frame_err_cnt_q <= 8'h00;
    end else begin
      frame_err_q <= malformed;
      if (malformed && frame_err_cnt_q != 8'hFF) frame_err_cnt_q <= frame_err_cnt_q + 8'd1;
    end
  end

  assign frame_err     = frame_err_q;
  assign frame_err_cnt = frame_err_cnt_q;
`else
  assign frame_err     = 1'b0;
  assign frame_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_intan_spi_responder.sv
// Directed bench for intan_spi_responder: drives SPI words at ~1/10 of bus_clk and checks the
// MISO word captured by the master two accepted words after each command.
module tb_intan_spi_responder;

  logic        bus_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        SCLK    = 1'b0;
  logic        CS      = 1'b1;
  logic        MOSI    = 1'b0;
  logic        MISO;
  logic        word_valid;
  logic [15:0] last_cmd;
  logic        frame_err;
  logic [7:0]  frame_err_cnt;

`ifdef INTAN_RESP_FRAME_CHECK_EN
  localparam int EXP_FE = 1;
`else
  localparam int EXP_FE = 0;
`endif

  intan_spi_responder dut (
    .bus_clk      (bus_clk),
    .reset        (reset),
    .SCLK         (SCLK),
    .CS           (CS),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .word_valid   (word_valid),
    .last_cmd     (last_cmd),
    .frame_err    (frame_err),
    .frame_err_cnt(frame_err_cnt)
  );

  always #5 bus_clk = ~bus_clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          wv_cnt = 0;
  int          fe_cnt = 0;
  int          wv_base, fe_base;
  logic [15:0] rx_word;

  always @(negedge bus_clk) begin
    if (word_valid) wv_cnt++;
    if (frame_err)  fe_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic cs_drop();
    @(negedge bus_clk);
    CS = 1'b0;
    #60;
  endtask

  // Master drives MOSI after each SCLK fall and samples MISO just before each SCLK rise.
  task automatic clock_bits(input logic [15:0] cmd, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      MOSI = cmd[15-i];
      #40;
      rx_word[15-i] = MISO;
      #10 SCLK = 1'b1;
      #50 SCLK = 1'b0;
    end
  endtask

  task automatic cs_raise();
    #50 CS = 1'b1;
    MOSI = 1'b0;
    #150;
  endtask

  task automatic send_word(input logic [15:0] cmd, input int n);
    rx_word = '0;
    cs_drop();
    clock_bits(cmd, 0, n);
    cs_raise();
  endtask

  task automatic word_chk(input string tag, input logic [15:0] cmd, input logic [15:0] exp);
    send_word(cmd, 16);
    check(tag, rx_word, exp);
  endtask

  task automatic pulse_reset();
    @(negedge bus_clk);
    reset = 1'b1;
    repeat (3) @(negedge bus_clk);
    reset = 1'b0;
    repeat (10) @(negedge bus_clk);
  endtask

  initial begin
    repeat (5) @(negedge bus_clk);
    check("rst_miso",       {15'b0, MISO}, 16'h0000);
    check("rst_word_valid", {15'b0, word_valid}, 16'h0000);
    check("rst_last_cmd",   last_cmd, 16'h0000);
    check("rst_fe_cnt",     {8'h00, frame_err_cnt}, 16'h0000);
    reset = 1'b0;
    repeat (10) @(negedge bus_clk);

    // READ(63) x3: chip id appears on the third word
    wv_base = wv_cnt;
    word_chk("id_w1", 16'hFF00, 16'h0000);
    word_chk("id_w2", 16'hFF00, 16'h0000);
    word_chk("id_w3", 16'hFF00, 16'h0001);
    check("id_last_cmd", last_cmd, 16'hFF00);
    check("id_wv_count", 16'(wv_cnt - wv_base), 16'd3);
    check("idle_miso",   {15'b0, MISO}, 16'h0000);

    // WRITE(5,0xA3) then READ(5) x3
    word_chk("wr_w1", 16'h85A3, 16'h0001);
    word_chk("wr_w2", 16'hC500, 16'h0001);
    word_chk("wr_w3", 16'hC500, 16'hFFA3);
    word_chk("wr_w4", 16'hC500, 16'h00A3);

    // ROM "INTAN" at 40..44 plus two dummy reads
    word_chk("rom_w1", 16'hE800, 16'h00A3);
    word_chk("rom_w2", 16'hE900, 16'h00A3);
    word_chk("rom_w3", 16'hEA00, 16'h0049);
    word_chk("rom_w4", 16'hEB00, 16'h004E);
    word_chk("rom_w5", 16'hEC00, 16'h0054);
    word_chk("rom_w6", 16'hC000, 16'h0041);
    word_chk("rom_w7", 16'hC000, 16'h004E);

    // Reset clears conv_cnt, pipeline and RAM; CONVERT(3) x4
    pulse_reset();
    word_chk("conv_w1", 16'h0300, 16'h0000);
    word_chk("conv_w2", 16'h0300, 16'h0000);
    word_chk("conv_w3", 16'h0300, 16'h0C00);
    word_chk("conv_w4", 16'h0300, 16'h0C01);
    word_chk("conv_w5", 16'hC500, 16'h0C02);
    word_chk("conv_w6", 16'hC000, 16'h0C03);
    word_chk("ram_cleared", 16'hC000, 16'h0000);

    // Out-of-range write, last RAM register, CALIBRATE
    word_chk("bnd_w1", 16'h9E55, 16'h0000);
    word_chk("bnd_w2", 16'hDE00, 16'h0000);
    word_chk("bnd_w3", 16'h957E, 16'hFF55);
    word_chk("reg30_unwritten", 16'hD500, 16'h0000);
    word_chk("bnd_w5", 16'h5500, 16'hFF7E);
    word_chk("reg21_readback", 16'hFF00, 16'h007E);
    word_chk("calibrate_zero", 16'hFF00, 16'h0000);

    // Malformed 12-edge word between two reads leaves the pipeline untouched
    wv_base = wv_cnt;
    fe_base = fe_cnt;
    word_chk("bad_w1", 16'hE800, 16'h0001);
    send_word(16'hFF00, 12);
    check("bad_miso",     rx_word, 16'h0000);
    check("bad_last_cmd", last_cmd, 16'hE800);
    check("bad_fe_pulse", 16'(fe_cnt - fe_base), 16'(EXP_FE));
    check("bad_fe_cnt",   {8'h00, frame_err_cnt}, 16'(EXP_FE));
    word_chk("bad_w2", 16'hE900, 16'h0001);
    word_chk("bad_w3", 16'hC000, 16'h0049);
    word_chk("bad_w4", 16'hC000, 16'h004E);
    check("bad_wv_count", 16'(wv_cnt - wv_base), 16'd4);

    // Reset asserted mid-word, released with CS still low: that word is discarded
    rx_word = '0;
    cs_drop();
    clock_bits(16'hFF00, 0, 4);
    @(negedge bus_clk);
    reset = 1'b1;
    repeat (4) @(negedge bus_clk);
    reset = 1'b0;
    repeat (4) @(negedge bus_clk);
    wv_base = wv_cnt;
    fe_base = fe_cnt;
    clock_bits(16'hFF00, 4, 12);
    cs_raise();
    check("midrst_wv",     16'(wv_cnt - wv_base), 16'd0);
    check("midrst_fe",     16'(fe_cnt - fe_base), 16'd0);
    check("midrst_fe_cnt", {8'h00, frame_err_cnt}, 16'h0000);
    check("midrst_last",   last_cmd, 16'h0000);
    word_chk("midrst_w1", 16'hFF00, 16'h0000);
    word_chk("midrst_w2", 16'hFF00, 16'h0000);
    word_chk("midrst_w3", 16'hFF00, 16'h0001);
    check("midrst_wv_count", 16'(wv_cnt - wv_base), 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/intan_spi_responder.md
INTAN_SPI_RESPONDER -- requirements
Module: intan_spi_responder

Interface
REQ-001 Parameter CHIP_ID, default 8'd1: value returned by READ of register 63.
REQ-002 Parameter RAM_REGS, default 22: registers 0..RAM_REGS-1 are writable 8-bit RAM.
REQ-003 bus_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 SCLK  in  1  SPI clock from the acquisition master; asynchronous to bus_clk.
REQ-006 CS  in  1  active-low word framing; asynchronous.
REQ-007 MOSI  in  1  command bit, MSB first; asynchronous.
REQ-008 MISO  out  1  response bit, MSB first.
REQ-009 word_valid  out  1  one-cycle pulse per accepted 16-bit command.
REQ-010 last_cmd  out  16  most recently accepted command.
REQ-011 frame_err  out  1  one-cycle pulse per malformed word.
REQ-012 frame_err_cnt  out  8  saturating malformed-word count.

Function
REQ-013 SCLK, CS and MOSI shall each pass a 2-flop synchronizer followed by one edge-detect register; operation requires bus_clk >= 8x SCLK.
REQ-014 A word shall start on a detected CS falling edge and end on a detected CS rising edge; an SCLK edge detected in the same cycle as a CS edge shall be ignored.
REQ-015 MOSI shall be shifted in on each detected SCLK rising edge while a word is active.
REQ-016 A word with exactly 16 rising edges shall be accepted: word_valid pulses and last_cmd updates in the cycle after CS-rise detection. Any other count is malformed: no decode, no register write, no pipeline advance.
REQ-017 Decode and response: CONVERT 00cccccc_xxxxxxxx -> {c[5:0], conv_cnt[9:0]}, then conv_cnt increments (10-bit, 1023 wraps to 0). WRITE 10rrrrrr_dddddddd -> 8'hFF,d; writes d to r only if r < RAM_REGS. READ 11rrrrrr_xxxxxxxx -> 8'h00,reg(r). Any 01xxxxxx command (CALIBRATE, CLEAR) -> 16'h0000.
REQ-018 READ map: RAM registers 0..RAM_REGS-1; ROM 40..44 = 0x49,0x4E,0x54,0x41,0x4E ("INTAN"); 63 = CHIP_ID; all others 0x00.
REQ-019 Response latency: the response to accepted word n shall be shifted out during accepted word n+2, via a 2-entry pipeline pushed at acceptance.
REQ-020 A write in word n shall be visible to a READ in word n+1.
REQ-021 On CS-fall detection, MISO shall present bit 15 of the oldest pipeline entry; each detected SCLK falling edge shall advance MISO to the next lower bit; after bit 0, MISO holds 0.
REQ-022 MISO shall change no later than 4 bus_clk cycles after the corresponding pin edge.
REQ-023 While CS is high, MISO shall be 0.

Reset
REQ-024 During reset: MISO, word_valid and frame_err = 0; last_cmd, pipeline entries, shift registers, RAM registers and conv_cnt = 0; frame_err_cnt = 0.
REQ-025 After reset, the responder shall be disarmed until a CS rising edge has been detected. A word in progress at reset release shall be discarded without counting as malformed.
REQ-026 Reset asserted mid-word shall abort the word with no side effects.

Configuration
REQ-027 Macro INTAN_RESP_FRAME_CHECK_EN defined: frame_err pulses on each malformed word, and frame_err_cnt increments, saturating at 255.
REQ-028 Macro INTAN_RESP_FRAME_CHECK_EN undefined: frame_err and frame_err_cnt tie to 0. Malformed words are still discarded per REQ-016.

Verification
REQ-029 Reset, then READ(63) x3 -> word-3 MISO = 0x0001; words 1-2 MISO = 0x0000.
REQ-030 WRITE(5,0xA3), READ(5), READ(5), READ(5) -> word-3 MISO = 0xFFA3; word-4 MISO = 0x00A3.
REQ-031 READ(40..44) followed by 2 dummy words -> MISO sequence 0x0049, 0x004E, 0x0054, 0x0041, 0x004E starting at word 3.
REQ-032 After reset, CONVERT(3) x4 -> word-3 MISO = 0x0C00; word-4 MISO = 0x0C01.
REQ-033 Word with 12 SCLK edges between two READ(63) words (macro defined) -> frame_err pulses once, frame_err_cnt = 1, and the pipeline is unchanged (second READ's response lands 2 accepted words later).
REQ-034 Reset released with CS low mid-word, word completed, then 3 full READ(63) words -> first word ignored (no word_valid, no frame_err); third full word MISO = 0x0001.
